// File: rtl/shale_bucket_bitmap_pkg.sv
// Shared constants and types for the Shale token-bucket eligibility stage.
// Widths mirror the PIEO datatypes so the bitmap plugs straight into curr_time_in.
package shale_bucket_bitmap_pkg;

  localparam int NULL_BUCKET    = 17;
  localparam int NUM_BUCKETS    = NULL_BUCKET;
  localparam int TIME_LOG       = 18;
  localparam int BITMAP_W       = TIME_LOG;
  localparam int ID_LOG         = 7;
  localparam int BUCKET_ID_W    = ID_LOG;
  localparam int TOKEN_LOG      = 4;
  localparam int TOKEN_W        = TOKEN_LOG;
  localparam int MAX_TOKENS     = 8;
  localparam int DEFAULT_REFILL = 1;
  localparam int CFG_ID_W       = $clog2(NUM_BUCKETS);

  typedef struct packed {
    logic [TOKEN_LOG-1:0] tokens;
    logic [TOKEN_LOG-1:0] refill;
    logic                 en;
  } bucket_state_t;

endpackage

// File: rtl/shale_bucket_bitmap_token_counter.sv
// One bucket's token counter: a dequeue decrements first, then a slot tick
// refills with saturation at MAX_TOKENS.
module shale_token_counter
  import shale_bucket_bitmap_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               deq_hit,
  input  logic               slot_tick,
  input  logic [TOKEN_W-1:0] refill,
  output logic [TOKEN_W-1:0] tokens_next,
  output logic               underflow
);

  localparam logic [TOKEN_W:0] CAP = (TOKEN_W+1)'(MAX_TOKENS);

  logic [TOKEN_W-1:0] tokens_q;
  logic [TOKEN_W-1:0] tokens_d;
  logic [TOKEN_W-1:0] after_deq;
  logic [TOKEN_W:0]   sum;

  always_comb begin
    after_deq = tokens_q;
    underflow = 1'b0;
    if (deq_hit) begin
      if (tokens_q != '0) after_deq = tokens_q - TOKEN_W'(1);
      else                underflow = 1'b1;
    end
    // One extra bit on the sum so a large refill clamps instead of wrapping.
    sum      = {1'b0, after_deq} + {1'b0, refill};
    tokens_d = after_deq;
    if (slot_tick) tokens_d = (sum > CAP) ? CAP[TOKEN_W-1:0] : sum[TOKEN_W-1:0];
  end

  assign tokens_next = tokens_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tokens_q <= '0;
    else        tokens_q <= tokens_d;
  end

endmodule

// File: rtl/shale_bucket_bitmap.sv
// Token-bucket eligibility stage feeding the Shale PIEO curr_time_in bitmap.
// Handles ID decode, bucket configuration, sticky errors and the output register.
module shale_bucket_bitmap
  import shale_bucket_bitmap_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CFG_ID_W-1:0]    cfg_id,
  input  logic [TOKEN_W-1:0]     cfg_refill,
  input  logic                   cfg_en,
  input  logic                   slot_tick,
  input  logic                   deq_valid,
  input  logic [BUCKET_ID_W-1:0] deq_bucket,
  output logic [BITMAP_W-1:0]    curr_time_out,
  output logic                   err_underflow,
  output logic                   err_bad_id,
  input  logic                   clr_err
);

  // deq_valid is a one-way strobe with no ready: every asserted cycle is one
  // dequeue and is always consumed in that same cycle.

  logic [TOKEN_W-1:0]     refill_q [NUM_BUCKETS];
  logic [TOKEN_W-1:0]     refill_d [NUM_BUCKETS];
  logic [TOKEN_W-1:0]     tokens_next [NUM_BUCKETS];
  logic [NUM_BUCKETS-1:0] en_q, en_d;
  logic [NUM_BUCKETS-1:0] deq_hit, underflow, nonzero;
  logic [BITMAP_W-1:0]    bitmap_q, bitmap_d;
  logic                   err_uf_q, err_uf_d;
  logic                   err_bad_q, err_bad_d;
  logic                   deq_id_ok, cfg_id_ok;

  assign deq_id_ok = int'(deq_bucket) < NUM_BUCKETS;
  assign cfg_id_ok = int'(cfg_id) < NUM_BUCKETS;

  for (genvar b = 0; b < NUM_BUCKETS; b++) begin : g_bucket
    assign deq_hit[b] = deq_valid && deq_id_ok && (int'(deq_bucket) == b);
    assign nonzero[b] = tokens_next[b] != '0;

    shale_token_counter u_counter (
      .clk         (clk),
      .rst_n       (rst_n),
      .deq_hit     (deq_hit[b]),
      .slot_tick   (slot_tick),
      .refill      (refill_q[b]),
      .tokens_next (tokens_next[b]),
      .underflow   (underflow[b])
    );
  end

  always_comb begin
    refill_d = refill_q;
    en_d     = en_q;
    // Counters read refill_q, so a tick alongside a write still uses the old value.
    if (cfg_we && cfg_id_ok) begin
      refill_d[cfg_id] = cfg_refill;
      en_d[cfg_id]     = cfg_en;
    end

    bitmap_d                  = '0;
    bitmap_d[NUM_BUCKETS-1:0] = en_q & nonzero;

    err_uf_d  = (err_uf_q && !clr_err) || (|underflow);
    err_bad_d = (err_bad_q && !clr_err)
             || (deq_valid && !deq_id_ok)
             || (cfg_we && !cfg_id_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUCKETS; i++) refill_q[i] <= TOKEN_W'(DEFAULT_REFILL);
      en_q      <= '1;
      bitmap_q  <= '0;
      err_uf_q  <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      refill_q  <= refill_d;
      en_q      <= en_d;
      bitmap_q  <= bitmap_d;
      err_uf_q  <= err_uf_d;
      err_bad_q <= err_bad_d;
    end
  end

  assign curr_time_out = bitmap_q;
  assign err_underflow = err_uf_q;
  assign err_bad_id    = err_bad_q;

endmodule

// File: tb/tb_shale_bucket_bitmap.sv
// Directed bench for shale_bucket_bitmap: a vector table from reset, then
// hand sequences for saturation, same-cycle ordering, enable and async reset.
module tb_shale_bucket_bitmap;

  localparam logic [17:0] ALL = 18'h1FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [4:0]  cfg_id;
  logic [3:0]  cfg_refill;
  logic        cfg_en;
  logic        slot_tick;
  logic        deq_valid;
  logic [6:0]  deq_bucket;
  logic [17:0] curr_time_out;
  logic        err_underflow;
  logic        err_bad_id;
  logic        clr_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        cfg_we;
    logic [4:0]  cfg_id;
    logic [3:0]  cfg_refill;
    logic        cfg_en;
    logic        tick;
    logic        deq_v;
    logic [6:0]  deq_b;
    logic        clr;
    logic [17:0] exp_bm;
    logic        exp_uf;
    logic        exp_bad;
  } vec_t;

  vec_t tbl[19];

  shale_bucket_bitmap dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_id        (cfg_id),
    .cfg_refill    (cfg_refill),
    .cfg_en        (cfg_en),
    .slot_tick     (slot_tick),
    .deq_valid     (deq_valid),
    .deq_bucket    (deq_bucket),
    .curr_time_out (curr_time_out),
    .err_underflow (err_underflow),
    .err_bad_id    (err_bad_id),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t v_op(input logic tick, input logic clr, input logic dv,
                                input logic [6:0] db, input logic [17:0] bm,
                                input logic uf, input logic bad);
    vec_t v;
    v.cfg_we = 1'b0; v.cfg_id = 5'd0; v.cfg_refill = 4'd0; v.cfg_en = 1'b0;
    v.tick = tick; v.clr = clr; v.deq_v = dv; v.deq_b = db;
    v.exp_bm = bm; v.exp_uf = uf; v.exp_bad = bad;
    return v;
  endfunction

  function automatic vec_t v_cfg(input logic [4:0] id, input logic [3:0] rf,
                                 input logic en, input logic tick,
                                 input logic [17:0] bm, input logic uf, input logic bad);
    vec_t v;
    v = v_op(tick, 1'b0, 1'b0, 7'd0, bm, uf, bad);
    v.cfg_we = 1'b1; v.cfg_id = id; v.cfg_refill = rf; v.cfg_en = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cfg_we = 1'b0; cfg_id = 5'd0; cfg_refill = 4'd0; cfg_en = 1'b0;
    slot_tick = 1'b0; deq_valid = 1'b0; deq_bucket = 7'd0; clr_err = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    cfg_we = v.cfg_we; cfg_id = v.cfg_id; cfg_refill = v.cfg_refill; cfg_en = v.cfg_en;
    slot_tick = v.tick; deq_valid = v.deq_v; deq_bucket = v.deq_b; clr_err = v.clr;
    @(posedge clk);
    #1;
    check({tag, ".bitmap"}, curr_time_out, v.exp_bm);
    check({tag, ".err_underflow"}, {17'd0, err_underflow}, {17'd0, v.exp_uf});
    check({tag, ".err_bad_id"}, {17'd0, err_bad_id}, {17'd0, v.exp_bad});
  endtask

  initial begin
    // Tokens tracked by hand: after reset all 0, refill 1, all enabled.
    tbl[0]  = v_op(1'b0, 1'b0, 1'b0, 7'd0,   18'h0,     1'b0, 1'b0);
    tbl[1]  = v_op(1'b1, 1'b0, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[2]  = v_op(1'b1, 1'b0, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[3]  = v_op(1'b1, 1'b0, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[4]  = v_op(1'b0, 1'b0, 1'b1, 7'd5,   ALL,       1'b0, 1'b0);
    tbl[5]  = v_op(1'b0, 1'b0, 1'b1, 7'd5,   ALL,       1'b0, 1'b0);
    tbl[6]  = v_op(1'b0, 1'b0, 1'b1, 7'd5,   18'h1FFDF, 1'b0, 1'b0);
    tbl[7]  = v_op(1'b0, 1'b0, 1'b1, 7'd5,   18'h1FFDF, 1'b1, 1'b0);
    tbl[8]  = v_op(1'b0, 1'b1, 1'b1, 7'd5,   18'h1FFDF, 1'b1, 1'b0);
    tbl[9]  = v_op(1'b0, 1'b1, 1'b0, 7'd0,   18'h1FFDF, 1'b0, 1'b0);
    tbl[10] = v_cfg(5'd2, 4'd15, 1'b1, 1'b1, ALL,       1'b0, 1'b0);
    tbl[11] = v_op(1'b1, 1'b0, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[12] = v_op(1'b1, 1'b0, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[13] = v_op(1'b0, 1'b0, 1'b1, 7'd17,  ALL,       1'b0, 1'b1);
    tbl[14] = v_op(1'b0, 1'b0, 1'b1, 7'd100, ALL,       1'b0, 1'b1);
    tbl[15] = v_op(1'b0, 1'b1, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);
    tbl[16] = v_cfg(5'd20, 4'd0, 1'b0, 1'b0, ALL,       1'b0, 1'b1);
    tbl[17] = v_op(1'b0, 1'b1, 1'b1, 7'd17,  ALL,       1'b0, 1'b1);
    tbl[18] = v_op(1'b0, 1'b1, 1'b0, 7'd0,   ALL,       1'b0, 1'b0);

    rst_n = 1'b0;
    drive_idle();
    #12;
    check("reset.bitmap", curr_time_out, 18'h0);
    check("reset.err_underflow", {17'd0, err_underflow}, 18'h0);
    check("reset.err_bad_id", {17'd0, err_bad_id}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Bucket 2 saturated at 8: exactly eight dequeues empty it.
    for (int i = 1; i <= 7; i++)
      apply(v_op(1'b0, 1'b0, 1'b1, 7'd2, ALL, 1'b0, 1'b0), $sformatf("sat_deq%0d", i));
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd2, 18'h1FFFB, 1'b0, 1'b0), "sat_deq8");
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd2, 18'h1FFFB, 1'b1, 1'b0), "sat_deq9");
    apply(v_op(1'b0, 1'b1, 1'b0, 7'd0, 18'h1FFFB, 1'b0, 1'b0), "sat_clr");

    // Bucket 7 (6 tokens): refill 2, drain, then dequeue+tick in one cycle.
    apply(v_cfg(5'd7, 4'd2, 1'b1, 1'b0, 18'h1FFFB, 1'b0, 1'b0), "b7_cfg");
    for (int i = 1; i <= 5; i++)
      apply(v_op(1'b0, 1'b0, 1'b1, 7'd7, 18'h1FFFB, 1'b0, 1'b0), $sformatf("b7_deq%0d", i));
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd7, 18'h1FF7B, 1'b0, 1'b0), "b7_deq6");
    apply(v_op(1'b1, 1'b0, 1'b1, 7'd7, ALL, 1'b1, 1'b0), "b7_deq_tick");
    apply(v_op(1'b0, 1'b1, 1'b0, 7'd0, ALL, 1'b0, 1'b0), "b7_clr");
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd7, ALL, 1'b0, 1'b0), "b7_left2");
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd7, 18'h1FF7F, 1'b0, 1'b0), "b7_left1");

    // Disable bucket 3: the bit drops one cycle after the write lands.
    apply(v_cfg(5'd3, 4'd1, 1'b0, 1'b0, 18'h1FF7F, 1'b0, 1'b0), "b3_cfg");
    apply(v_op(1'b0, 1'b0, 1'b0, 7'd0, 18'h1FF77, 1'b0, 1'b0), "b3_off");
    apply(v_op(1'b1, 1'b0, 1'b0, 7'd0, 18'h1FFF7, 1'b0, 1'b0), "b3_tick");
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd100, 18'h1FFF7, 1'b0, 1'b1), "pre_rst_bad");

    // Asynchronous reset between clock edges.
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.bitmap", curr_time_out, 18'h0);
    check("async_rst.err_underflow", {17'd0, err_underflow}, 18'h0);
    check("async_rst.err_bad_id", {17'd0, err_bad_id}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(v_op(1'b0, 1'b0, 1'b0, 7'd0, 18'h0, 1'b0, 1'b0), "post_rst_idle");
    apply(v_op(1'b1, 1'b0, 1'b0, 7'd0, ALL, 1'b0, 1'b0), "post_rst_tick");
    apply(v_op(1'b0, 1'b0, 1'b1, 7'd2, 18'h1FFFB, 1'b0, 1'b0), "post_rst_refill2");

    @(negedge clk);
    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
